// File: rtl/master_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : master_spi_pkg
// Purpose : Shared types and constants for the master_spi interconnect master.
//           Holds the default instruction width, the destination codes carried
//           on the enable bus, and the transfer state encoding.
// Config  : MASTER_SPI_BROADCAST_EN (consumed by master_spi, not here)
// Revision: 1.0 - initial release
// ============================================================================
package master_spi_pkg;

    localparam int DATA_W_DEF = 32;

    // Destination codes on the enable bus
    localparam logic [1:0] DEST_SELF  = 2'b00;
    localparam logic [1:0] DEST_LEFT  = 2'b01;
    localparam logic [1:0] DEST_RIGHT = 2'b10;
    localparam logic [1:0] DEST_BCAST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : master_spi_pkg
`default_nettype wire

// File: rtl/master_spi_shift_link.sv
`default_nettype none
// ============================================================================
// Module  : spi_shift_link
// Purpose : Bit-serial loop between a transmit and a receive shift register,
//           MSB first, one bit every CLK_DIV clocks while shift_i is high.
// Ports   : clk, rst_n      clock / asynchronous active-low reset
//           load_i          capture data_i into tx, clear rx and counters
//           data_i          word to serialise
//           shift_i         advance the link (divider runs only while high)
//           done_o          high on the edge that moves the last bit
//           rx_word_o       receive word as it will be after the current shift
// Revision: 1.0 - initial release
// ============================================================================
module spi_shift_link #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_word_o
);

    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic              w_strobe;

    // Bit strobe fires on the CLK_DIV-th shifting edge after load
    assign w_strobe  = shift_i && (div_cnt_q == DIV_LAST);
    assign done_o    = w_strobe && (bit_cnt_q == LAST_BIT);
    assign rx_word_o = {rx_q[DATA_W-2:0], tx_q[DATA_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else if (load_i) begin
            tx_q      <= data_i;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else if (w_strobe) begin
            rx_q      <= rx_word_o;
            tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            div_cnt_q <= '0;
        end else if (shift_i) begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

endmodule : spi_shift_link
`default_nettype wire

// File: rtl/master_spi.sv
`default_nettype none
// ============================================================================
// Module  : master_spi
// Purpose : Interconnect master. Captures an instruction and destination code,
//           pushes the word through the serial shift link and re-assembles it
//           on out_instr, pulsing the check output of the addressed node.
// Ports   : clk, rst_n                 clock / asynchronous active-low reset
//           enable[1:0]                00 self, 01 left, 10 right, 11 broadcast
//           in_instr[DATA_W-1:0]       word to transfer
//           check_self/left/right      one-cycle completion pulses
//           out_instr[DATA_W-1:0]      last fully received word
// Config  : MASTER_SPI_BROADCAST_EN - code 11 becomes valid and pulses all
//           three checks; otherwise code 11 is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module master_spi
    import master_spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        enable,
    input  logic [DATA_W-1:0] in_instr,
    output logic              check_self,
    output logic              check_left,
    output logic              check_right,
    output logic [DATA_W-1:0] out_instr
);

    state_t            state_q;
    logic [1:0]        dest_q;
    logic [DATA_W-1:0] out_instr_q;
    logic              check_self_q;
    logic              check_left_q;
    logic              check_right_q;

    logic              w_code_valid;
    logic              w_bcast;
    logic              w_load;
    logic              w_done;
    logic [DATA_W-1:0] w_rx_word;

`ifdef MASTER_SPI_BROADCAST_EN
    assign w_code_valid = 1'b1;
    assign w_bcast      = (dest_q == DEST_BCAST);
`else
    assign w_code_valid = (enable != DEST_BCAST);
    assign w_bcast      = 1'b0;
`endif

    assign w_load = (state_q == ST_IDLE) && w_code_valid;

    spi_shift_link #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_link (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (w_load),
        .data_i    (in_instr),
        .shift_i   (state_q == ST_SHIFT),
        .done_o    (w_done),
        .rx_word_o (w_rx_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dest_q        <= DEST_SELF;
            out_instr_q   <= '0;
            check_self_q  <= 1'b0;
            check_left_q  <= 1'b0;
            check_right_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_code_valid) begin
                        dest_q  <= enable;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Final shift: publish the completed word and its check
                    if (w_done) begin
                        out_instr_q   <= w_rx_word;
                        check_self_q  <= (dest_q == DEST_SELF)  || w_bcast;
                        check_left_q  <= (dest_q == DEST_LEFT)  || w_bcast;
                        check_right_q <= (dest_q == DEST_RIGHT) || w_bcast;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    check_self_q  <= 1'b0;
                    check_left_q  <= 1'b0;
                    check_right_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_instr   = out_instr_q;
    assign check_self  = check_self_q;
    assign check_left  = check_left_q;
    assign check_right = check_right_q;

endmodule : master_spi
`default_nettype wire

// File: tb/tb_master_spi.sv
`default_nettype none
// ============================================================================
// Module  : tb_master_spi
// Purpose : Scoreboard bench for master_spi. A transaction-level reference
//           predicts when each capture happens and what completes when; a
//           monitor compares every cycle against the predicted stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_master_spi;

    localparam int DW      = 32;
    localparam int CLK_DIV = 1;
    localparam int XFER    = DW * CLK_DIV;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    chk;   // {right, left, self}
        int            due;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [1:0]    enable;
    logic [DW-1:0] in_instr;
    logic          check_self;
    logic          check_left;
    logic          check_right;
    logic [DW-1:0] out_instr;

    exp_t          q[$];
    int            edge_n;
    int            next_free;
    logic [DW-1:0] exp_out;
    int            checks;
    int            errors;

    master_spi #(
        .DATA_W  (DW),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_instr    (in_instr),
        .check_self  (check_self),
        .check_left  (check_left),
        .check_right (check_right),
        .out_instr   (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which check lines a destination code should raise; 0 = not a transfer
    function automatic logic [2:0] dest_mask(input logic [1:0] code);
        case (code)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
`ifdef MASTER_SPI_BROADCAST_EN
            default: return 3'b111;
`else
            default: return 3'b000;
`endif
        endcase
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: a transfer is accepted whenever the master is free and the
    // code is valid; it completes XFER edges later and the master is free
    // again two edges after completion.
    initial begin
        edge_n    = 0;
        next_free = 0;
        exp_out   = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst_n === 1'b1 && edge_n >= next_free && dest_mask(enable) != 3'b000) begin
                q.push_back('{data: in_instr, chk: dest_mask(enable), due: edge_n + XFER});
                next_free = edge_n + XFER + 2;
            end
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        next_free = 0;
        exp_out   = '0;
    end

    // Monitor
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            logic [2:0] seen;
            exp_t       e;
            @(negedge clk);
            seen = {check_right, check_left, check_self};
            if (seen != 3'b000) begin
                if (q.size() == 0) begin
                    cmp("unexpected_check", {29'd0, seen}, '0);
                end else begin
                    e = q.pop_front();
                    cmp("check_vec", {29'd0, seen}, {29'd0, e.chk});
                    cmp("out_instr", out_instr, e.data);
                    cmp("latency_edge", DW'(edge_n), DW'(e.due));
                    exp_out = e.data;
                end
            end else begin
                if (q.size() != 0 && edge_n > q[0].due) begin
                    e = q.pop_front();
                    cmp("missing_check", {29'd0, seen}, {29'd0, e.chk});
                end
                cmp("out_hold", out_instr, exp_out);
            end
        end
    end

    task automatic drive(input logic [1:0] en, input logic [DW-1:0] d, input int cycles);
        @(posedge clk); #2;
        enable   = en;
        in_instr = d;
        repeat (cycles - 1) @(posedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 2'b11;
        in_instr = '0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed transfers to each destination
        drive(2'b10, 32'd10000, XFER + 2);
        drive(2'b00, 32'd30000, XFER + 2);
        drive(2'b01, 32'd50000, XFER + 2);

        // Input change while shifting must not disturb the word in flight
        drive(2'b10, 32'd10000, 10);
        drive(2'b10, 32'hFFFF_FFFF, 2 * XFER + 6);

        // Reset in the middle of a transfer, then a clean one
        pulse_reset(2);
        drive(2'b00, 32'h1234_5678, 16);
        pulse_reset(3);
        drive(2'b01, 32'hA5A5_0F0F, XFER + 4);

        // Broadcast / invalid code
        drive(2'b11, 32'd7, 100);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 24) == 0)
                pulse_reset($urandom_range(1, 4));
            drive(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 80));
        end

        // Drain: park on the invalid code and let everything in flight finish
        drive(2'b11, 32'd0, 2 * XFER + 8);
        @(negedge clk);
        for (int i = 0; i < q.size(); i++)
            cmp("drain_overdue", DW'(q[i].due < edge_n), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_master_spi
`default_nettype wire
